vram_console_writer: RTL

Character-stream front end for the 80x50 text display: accepts ASCII bytes on a valid/ready handshake, maintains a cursor, and writes {attribute, character} words into the character VRAM. It drives the VGA text interface's write port (IO_Address, IO_Write_Data, WR) directly and sits immediately upstream of that interface. It handles CR, LF, and backspace. When the cursor moves onto a new row, that row is cleared.

---
 rtl/vram_console_pkg.sv | 43 ++++
 rtl/vram_console_cursor.sv | 77 +++++++
 rtl/vram_console_writer.sv | 196 +++++++++++++++++++
 3 files changed

// File: rtl/vram_console_pkg.sv
// Shared constants, state encoding and cell arithmetic for the 80x50 VRAM console writer.
// Optional clear-screen (FF) support is enabled by defining VRAM_CONSOLE_FF_EN.
package vram_console_pkg;

  localparam int CONS_COLS = 80;
  localparam int CONS_ROWS = 50;

  localparam logic [7:0] CH_BS = 8'h08;
  localparam logic [7:0] CH_LF = 8'h0A;
  localparam logic [7:0] CH_FF = 8'h0C;
  localparam logic [7:0] CH_CR = 8'h0D;
  localparam logic [7:0] CH_SP = 8'h20;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_PUT  = 2'd1,
    ST_CLR  = 2'd2
`ifdef VRAM_CONSOLE_FF_EN
    , ST_FF = 2'd3
`endif
  } state_e;

  typedef enum logic [2:0] {
    CMD_NONE = 3'd0,
    CMD_ADV  = 3'd1,
    CMD_CR   = 3'd2,
    CMD_NL   = 3'd3,
    CMD_BS   = 3'd4,
    CMD_HOME = 3'd5
  } cursor_cmd_e;

  // row*80 + col without a multiplier: (row<<6) + (row<<4) + col
  function automatic logic [11:0] cell_index(input logic [5:0] row, input logic [6:0] col);
    logic [11:0] w_row_ext;
    w_row_ext = {6'd0, row};
    return (w_row_ext << 6) + (w_row_ext << 4) + {5'd0, col};
  endfunction

  function automatic logic [31:0] vram_word(input logic [7:0] attr, input logic [6:0] ch);
    return {16'h0000, attr, 1'b0, ch};
  endfunction

endpackage

// File: rtl/vram_console_cursor.sv
// Cursor row/column counters with advance, carriage return, newline, backspace and home commands.
module vram_console_cursor
  import vram_console_pkg::*;
#(
  parameter int COLS = CONS_COLS,
  parameter int ROWS = CONS_ROWS
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  cursor_cmd_e i_cmd,
  output logic [6:0]  o_col,
  output logic [5:0]  o_row,
  output logic [5:0]  o_row_next,
  output logic        o_row_adv
);

  logic [6:0] r_col;
  logic [5:0] r_row;
  logic [6:0] w_col_d;
  logic [5:0] w_row_d;
  logic [5:0] w_row_next;
  logic       w_row_adv;

  assign w_row_next = (r_row == 6'(ROWS - 1)) ? 6'd0 : r_row + 6'd1;

  // Next cursor position; o_row_adv flags commands that move onto a new row
  always_comb begin
    w_col_d   = r_col;
    w_row_d   = r_row;
    w_row_adv = 1'b0;
    case (i_cmd)
      CMD_ADV: begin
        if (r_col == 7'(COLS - 1)) begin
          w_col_d   = 7'd0;
          w_row_d   = w_row_next;
          w_row_adv = 1'b1;
        end else begin
          w_col_d = r_col + 7'd1;
        end
      end
      CMD_CR: w_col_d = 7'd0;
      CMD_NL: begin
        w_col_d   = 7'd0;
        w_row_d   = w_row_next;
        w_row_adv = 1'b1;
      end
      CMD_BS: begin
        if (r_col != 7'd0) begin
          w_col_d = r_col - 7'd1;
        end else begin
          w_col_d = r_col;
        end
      end
      CMD_HOME: begin
        w_col_d = 7'd0;
        w_row_d = 6'd0;
      end
      default: w_col_d = r_col;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_col <= 7'd0;
      r_row <= 6'd0;
    end else begin
      r_col <= w_col_d;
      r_row <= w_row_d;
    end
  end

  assign o_col      = r_col;
  assign o_row      = r_row;
  assign o_row_next = w_row_next;
  assign o_row_adv  = w_row_adv;

endmodule

// File: rtl/vram_console_writer.sv
// Character stream to 80x50 text VRAM writer: cursor handling, CR/LF/BS, and new-row clearing.
// Define VRAM_CONSOLE_FF_EN to make 0x0C clear the whole screen and home the cursor.
module vram_console_writer
  import vram_console_pkg::*;
#(
  parameter int          COLS      = CONS_COLS,
  parameter int          ROWS      = CONS_ROWS,
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic [7:0]  CH_DATA,
  input  logic        CH_VALID,
  output logic        CH_READY,
  input  logic [7:0]  ATTR,
  output logic [31:0] IO_Address,
  output logic [31:0] IO_Write_Data,
  output logic        WR,
  output logic [6:0]  CUR_COL,
  output logic [5:0]  CUR_ROW
);

  state_e      r_state, w_state_d;
  cursor_cmd_e w_cmd;
  logic        r_wr, w_wr_d;
  logic [31:0] r_addr, w_addr_d;
  logic [31:0] r_data, w_data_d;
  logic [7:0]  r_attr, w_attr_d;
  logic        r_is_bs, w_is_bs_d;
  logic [6:0]  r_clr_col, w_clr_col_d;
  logic [6:0]  w_col;
  logic [5:0]  w_row, w_row_next;
  logic        w_row_adv, w_hs, w_printable;
`ifdef VRAM_CONSOLE_FF_EN
  logic [11:0] r_ff_idx, w_ff_idx_d;
`endif

  function automatic logic [31:0] cell_addr(input logic [11:0] idx);
    return BASE_ADDR + {18'd0, idx, 2'b00};
  endfunction

  vram_console_cursor #(.COLS(COLS), .ROWS(ROWS)) u_cursor (
    .i_clk      (CLK),
    .i_rst      (RST),
    .i_cmd      (w_cmd),
    .o_col      (w_col),
    .o_row      (w_row),
    .o_row_next (w_row_next),
    .o_row_adv  (w_row_adv)
  );

  assign CH_READY    = (r_state == ST_IDLE);
  assign w_hs        = CH_VALID && (r_state == ST_IDLE);
  assign w_printable = (CH_DATA >= 8'h20) && (CH_DATA <= 8'h7E);

  // Cursor command; kept apart from the FSM so the wrap flag never feeds back into it
  always_comb begin
    w_cmd = CMD_NONE;
    case (r_state)
      ST_IDLE: begin
        if (w_hs && (CH_DATA == CH_CR)) begin
          w_cmd = CMD_CR;
        end else if (w_hs && (CH_DATA == CH_LF)) begin
          w_cmd = CMD_NL;
        end else begin
          w_cmd = CMD_NONE;
        end
      end
      ST_PUT: w_cmd = r_is_bs ? CMD_BS : CMD_ADV;
`ifdef VRAM_CONSOLE_FF_EN
      ST_FF: w_cmd = (r_ff_idx == 12'(COLS * ROWS)) ? CMD_HOME : CMD_NONE;
`endif
      default: w_cmd = CMD_NONE;
    endcase
  end

  always_comb begin
    w_state_d   = r_state;
    w_wr_d      = 1'b0;
    w_addr_d    = r_addr;
    w_data_d    = r_data;
    w_attr_d    = r_attr;
    w_is_bs_d   = r_is_bs;
    w_clr_col_d = r_clr_col;
`ifdef VRAM_CONSOLE_FF_EN
    w_ff_idx_d  = r_ff_idx;
`endif
    case (r_state)
      ST_IDLE: begin
        if (w_hs) begin
          w_attr_d = ATTR;
          if (w_printable) begin
            w_wr_d    = 1'b1;
            w_addr_d  = cell_addr(cell_index(w_row, w_col));
            w_data_d  = vram_word(ATTR, CH_DATA[6:0]);
            w_is_bs_d = 1'b0;
            w_state_d = ST_PUT;
          end else if ((CH_DATA == CH_BS) && (w_col != 7'd0)) begin
            w_wr_d    = 1'b1;
            w_addr_d  = cell_addr(cell_index(w_row, w_col - 7'd1));
            w_data_d  = vram_word(ATTR, CH_SP[6:0]);
            w_is_bs_d = 1'b1;
            w_state_d = ST_PUT;
          end else if (CH_DATA == CH_LF) begin
            w_wr_d      = 1'b1;
            w_addr_d    = cell_addr(cell_index(w_row_next, 7'd0));
            w_data_d    = vram_word(ATTR, CH_SP[6:0]);
            w_clr_col_d = 7'd1;
            w_state_d   = ST_CLR;
`ifdef VRAM_CONSOLE_FF_EN
          end else if (CH_DATA == CH_FF) begin
            w_wr_d     = 1'b1;
            w_addr_d   = cell_addr(12'd0);
            w_data_d   = vram_word(ATTR, CH_SP[6:0]);
            w_ff_idx_d = 12'd1;
            w_state_d  = ST_FF;
`endif
          end else begin
            w_state_d = ST_IDLE;
          end
        end else begin
          w_state_d = ST_IDLE;
        end
      end
      ST_PUT: begin
        if (w_row_adv) begin
          w_wr_d      = 1'b1;
          w_addr_d    = cell_addr(cell_index(w_row_next, 7'd0));
          w_data_d    = vram_word(r_attr, CH_SP[6:0]);
          w_clr_col_d = 7'd1;
          w_state_d   = ST_CLR;
        end else begin
          w_state_d = ST_IDLE;
        end
      end
      ST_CLR: begin
        if (r_clr_col < 7'(COLS)) begin
          w_wr_d      = 1'b1;
          w_addr_d    = cell_addr(cell_index(w_row, r_clr_col));
          w_data_d    = vram_word(r_attr, CH_SP[6:0]);
          w_clr_col_d = r_clr_col + 7'd1;
        end else begin
          w_clr_col_d = 7'd0;
          w_state_d   = ST_IDLE;
        end
      end
`ifdef VRAM_CONSOLE_FF_EN
      ST_FF: begin
        if (r_ff_idx < 12'(COLS * ROWS)) begin
          w_wr_d     = 1'b1;
          w_addr_d   = cell_addr(r_ff_idx);
          w_data_d   = vram_word(r_attr, CH_SP[6:0]);
          w_ff_idx_d = r_ff_idx + 12'd1;
        end else begin
          w_ff_idx_d = 12'd0;
          w_state_d  = ST_IDLE;
        end
      end
`endif
      default: w_state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_state   <= ST_IDLE;
      r_wr      <= 1'b0;
      r_addr    <= BASE_ADDR;
      r_data    <= 32'd0;
      r_attr    <= 8'd0;
      r_is_bs   <= 1'b0;
      r_clr_col <= 7'd0;
`ifdef VRAM_CONSOLE_FF_EN
      r_ff_idx  <= 12'd0;
`endif
    end else begin
      r_state   <= w_state_d;
      r_wr      <= w_wr_d;
      r_addr    <= w_addr_d;
      r_data    <= w_data_d;
      r_attr    <= w_attr_d;
      r_is_bs   <= w_is_bs_d;
      r_clr_col <= w_clr_col_d;
`ifdef VRAM_CONSOLE_FF_EN
      r_ff_idx  <= w_ff_idx_d;
`endif
    end
  end

  assign WR            = r_wr;
  assign IO_Address    = r_addr;
  assign IO_Write_Data = r_data;
  assign CUR_COL       = w_col;
  assign CUR_ROW       = w_row;

endmodule
